// File: rtl/kmeans_scheduler_if.sv
// Scheduler bus: image memory read port, pixel broadcast to cores, core
// status/labels and label-memory write-back.
interface kmeans_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int PIX_W  = 24
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              cores_busy;
  logic              compare_only;
  logic              update_mean;
  logic              means_stable;
  logic              label_valid;
  logic [3:0]        label_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;

  modport master (
    output mem_rd, mem_addr, pix_valid, pix_data, compare_only, update_mean,
           wr_en, wr_addr, wr_data,
    input  mem_rdata, cores_busy, means_stable, label_valid, label_in
  );

  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix_data, compare_only, update_mean,
           wr_en, wr_addr, wr_data,
    output mem_rdata, cores_busy, means_stable, label_valid, label_in
  );
endinterface

// File: rtl/kmeans_scheduler.sv
// K-means run sequencer: learning passes over the image until the cores report
// stable means or the iteration cap is hit, then one labelling write-back pass.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for start after reset
// FETCH       | read request for pixel addr (learning pass)
// ISSUE       | pixel broadcast, held until cores accept
// UPDATE      | one-cycle mean-update pulse, iteration counted
// UPDATE_WAIT | cores recompute means; decide next pass
// WFETCH      | read request for pixel addr (write pass)
// WISSUE      | pixel broadcast in compare-only mode
// WLABEL      | wait for closest-core index, write it back
// DONE        | run finished, results held until next start
module kmeans_scheduler #(
  parameter int ADDR_W   = 12,
  parameter int PIX_W    = 24,
  parameter int MAX_ITER = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   image_size,
  input  logic [3:0]          k_cores,
  kmeans_scheduler_if.master  bus,
  output logic                done,
  output logic                converged,
  output logic [5:0]          iter_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, ISSUE, UPDATE, UPDATE_WAIT, WFETCH, WISSUE, WLABEL, DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [ADDR_W-1:0] n_lat, n_nx;
  logic [5:0]        iter_nx;
  logic              conv_nx;
  logic              rd_pend;
  logic [PIX_W-1:0]  pix_reg;
  logic              last_pix;
  logic [PIX_W-1:0]  pix_cur;

  assign last_pix = (addr == n_lat - ADDR_W'(1));
  // Read data arrives in the first issue cycle; later stall cycles replay the copy.
  assign pix_cur  = rd_pend ? bus.mem_rdata : pix_reg;

  always_comb begin
    state_nx         = state;
    addr_nx          = addr;
    n_nx             = n_lat;
    iter_nx          = iter_count;
    conv_nx          = converged;
    done             = 1'b0;
    bus.mem_rd       = 1'b0;
    bus.mem_addr     = '0;
    bus.pix_valid    = 1'b0;
    bus.pix_data     = '0;
    bus.compare_only = 1'b0;
    bus.update_mean  = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          n_nx     = image_size;
          addr_nx  = '0;
          iter_nx  = '0;
          conv_nx  = 1'b0;
          state_nx = (image_size == '0 || k_cores == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr;
        state_nx     = ISSUE;
      end
      ISSUE: begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = pix_cur;
        if (!bus.cores_busy) begin
          if (last_pix) begin
            addr_nx  = '0;
            state_nx = UPDATE;
          end else begin
            addr_nx  = addr + ADDR_W'(1);
            state_nx = FETCH;
          end
        end
      end
      UPDATE: begin
        bus.update_mean = 1'b1;
        iter_nx         = iter_count + 6'd1;
        state_nx        = UPDATE_WAIT;
      end
      UPDATE_WAIT: begin
        if (!bus.cores_busy) begin
          if (bus.means_stable) begin
            conv_nx  = 1'b1;
            state_nx = WFETCH;
          end else if (iter_count == 6'(MAX_ITER)) begin
            state_nx = WFETCH;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      WFETCH: begin
        bus.mem_rd       = 1'b1;
        bus.mem_addr     = addr;
        bus.compare_only = 1'b1;
        state_nx         = WISSUE;
      end
      WISSUE: begin
        bus.pix_valid    = 1'b1;
        bus.pix_data     = pix_cur;
        bus.compare_only = 1'b1;
        if (!bus.cores_busy) state_nx = WLABEL;
      end
      WLABEL: begin
        bus.compare_only = 1'b1;
        if (bus.label_valid) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = addr;
          bus.wr_data = bus.label_in;
          if (last_pix) begin
            state_nx = DONE;
          end else begin
            addr_nx  = addr + ADDR_W'(1);
            state_nx = WFETCH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      n_lat      <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      rd_pend    <= 1'b0;
      pix_reg    <= '0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      n_lat      <= n_nx;
      iter_count <= iter_nx;
      converged  <= conv_nx;
      rd_pend    <= bus.mem_rd;
      if (rd_pend) pix_reg <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_kmeans_scheduler.sv
// Directed bench for kmeans_scheduler: an ordered queue of expected bus events
// (reads, transfers, updates, writes) is derived from the run parameters.
module tb_kmeans_scheduler;
  localparam int ADDR_W   = 12;
  localparam int PIX_W    = 24;
  localparam int MAX_ITER = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] image_size = '0;
  logic [3:0]        k_cores = '0;
  logic              done, converged;
  logic [5:0]        iter_count;

  kmeans_scheduler_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  kmeans_scheduler #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .image_size(image_size),
    .k_cores(k_cores), .bus(bus), .done(done), .converged(converged),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  localparam int EV_RD = 0, EV_XF = 1, EV_UPD = 2, EV_WR = 3;
  typedef struct {int kind; int addr; bit co;} ev_t;
  ev_t exp_q[$];

  int checks = 0, errors = 0;
  int cfg_stab = 0, cfg_stall = -1, cfg_ldly = 0;
  bit cfg_ubusy = 0;
  int upd_cnt = 0, lxf_cnt = 0, wxf_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int cur_addr = 0, lab_addr = 0, lab_cnt = -1, stall_cnt = 0, ubusy_cnt = 0;
  bit stall_done = 0;
  bit nx_busy, nx_lv, nx_ms;
  logic [3:0] nx_li;
  logic [23:0] junk = 24'd0;

  function automatic logic [PIX_W-1:0] pix_of(input int a);
    logic [7:0] r, g, b;
    r = 8'(a * 37 + 11);
    g = 8'(a * 13 + 200);
    b = 8'(255 - a);
    return {r, g, b};
  endfunction

  function automatic logic [3:0] lab_of(input int a);
    return 4'(a * 5 + 3);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic take(input int kind, input string nm, output ev_t e);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event expected none", nm);
      e.kind = -1; e.addr = -1; e.co = 1'b0;
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
    end
  endtask

  task automatic push(input int kind, input int a, input bit co);
    ev_t e;
    e.kind = kind; e.addr = a; e.co = co;
    exp_q.push_back(e);
  endtask

  // Reference: passes until stable or capped, then one write pass.
  task automatic build(input int n, input int k, input int stab,
                       output int mi, output bit mc, output int mrd);
    exp_q.delete();
    if (n == 0 || k == 0) begin
      mi = 0; mc = 0; mrd = 0;
      return;
    end
    if (stab != 0 && stab <= MAX_ITER) begin mi = stab; mc = 1; end
    else begin mi = MAX_ITER; mc = 0; end
    mrd = (mi + 1) * n;
    for (int it = 0; it < mi; it++) begin
      for (int a = 0; a < n; a++) begin
        push(EV_RD, a, 1'b0);
        push(EV_XF, a, 1'b0);
      end
      push(EV_UPD, 0, 1'b0);
    end
    for (int a = 0; a < n; a++) begin
      push(EV_RD, a, 1'b1);
      push(EV_XF, a, 1'b1);
      push(EV_WR, a, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    junk <= junk + 24'd1;
    bus.mem_rdata <= bus.mem_rd ? pix_of(int'(bus.mem_addr)) : (24'hBAD000 ^ junk);
  end

  // Compare process: checks settled outputs, then drives the core-side inputs
  // just after the following rising edge.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      exp_q.delete();
      lab_cnt = -1; stall_cnt = 0; ubusy_cnt = 0;
      nx_busy = 0; nx_lv = 0; nx_li = '0; nx_ms = 0;
    end else begin
      chk("exclusive", ($countones({bus.mem_rd, bus.pix_valid, bus.update_mean, bus.wr_en}) <= 1), 1);
      if (bus.mem_rd) begin
        take(EV_RD, "read", e);
        chk("rd_addr", bus.mem_addr, e.addr);
        chk("rd_pass", bus.compare_only, e.co);
        cur_addr = int'(bus.mem_addr);
        rd_cnt++;
        if (!bus.compare_only && cur_addr == cfg_stall && !stall_done) begin
          stall_cnt = 5;
          stall_done = 1;
        end
      end
      if (bus.pix_valid) chk("pix_data", bus.pix_data, pix_of(cur_addr));
      if (bus.pix_valid && !bus.cores_busy) begin
        take(EV_XF, "xfer", e);
        chk("xf_pass", bus.compare_only, e.co);
        if (!bus.compare_only) lxf_cnt++;
        else begin
          wxf_cnt++;
          lab_cnt = cfg_ldly;
          lab_addr = cur_addr;
        end
      end
      if (bus.update_mean) begin
        take(EV_UPD, "update", e);
        upd_cnt++;
        if (cfg_ubusy) ubusy_cnt = 3;
      end
      if (bus.wr_en) begin
        take(EV_WR, "write", e);
        chk("wr_addr", bus.wr_addr, e.addr);
        chk("wr_data", bus.wr_data, lab_of(e.addr));
        wr_cnt++;
      end
      nx_busy = (stall_cnt > 0) || (ubusy_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      if (ubusy_cnt > 0) ubusy_cnt--;
      nx_lv = bus.label_valid && !bus.wr_en;
      nx_li = bus.label_in;
      if (lab_cnt > 0) begin
        lab_cnt--;
        nx_li = ~lab_of(lab_addr);
      end else if (lab_cnt == 0) begin
        nx_lv = 1;
        nx_li = lab_of(lab_addr);
        lab_cnt = -1;
      end
      nx_ms = (cfg_stab != 0) && (upd_cnt >= cfg_stab);
    end
    @(posedge clk);
    #1;
    bus.cores_busy   = nx_busy;
    bus.label_valid  = nx_lv;
    bus.label_in     = nx_li;
    bus.means_stable = nx_ms;
  end

  task automatic setup(input int stab, input int stall, input int ldly, input bit ubusy);
    cfg_stab = stab; cfg_stall = stall; cfg_ldly = ldly; cfg_ubusy = ubusy;
    upd_cnt = 0; lxf_cnt = 0; wxf_cnt = 0; wr_cnt = 0; rd_cnt = 0; stall_done = 0;
  endtask

  task automatic run(input string nm, input int n, input int k, input int stab,
                     input int stall, input int ldly, input bit ubusy,
                     input int lit_iter, input bit lit_conv, input int lit_lxf,
                     input int lit_wr);
    int mi, mrd, lim;
    bit mc, seen;
    build(n, k, stab, mi, mc, mrd);
    setup(stab, stall, ldly, ubusy);
    @(negedge clk);
    image_size = ADDR_W'(n); k_cores = 4'(k); start = 1'b1;
    @(negedge clk);
    start = 1'b0; image_size = ADDR_W'(n + 5); k_cores = 4'(k + 1);
    if (n > 2 && k > 0) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    lim = (n == 0 || k == 0) ? 2 : 3000;
    seen = 0;
    for (int c = 0; c < lim; c++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({nm, " done"}, seen, 1);
    chk({nm, " converged"}, converged, mc);
    chk({nm, " converged_lit"}, converged, lit_conv);
    chk({nm, " iter_count"}, iter_count, mi);
    chk({nm, " iter_count_lit"}, iter_count, lit_iter);
    chk({nm, " learn_xfers"}, lxf_cnt, lit_lxf);
    chk({nm, " writes"}, wr_cnt, lit_wr);
    chk({nm, " updates"}, upd_cnt, lit_iter);
    chk({nm, " reads"}, rd_cnt, mrd);
    chk({nm, " pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int mi, mrd;
    bit mc;
    repeat (2) @(negedge clk);
    chk("rst mem_rd", bus.mem_rd, 0);
    chk("rst pix_valid", bus.pix_valid, 0);
    chk("rst update_mean", bus.update_mean, 0);
    chk("rst wr_en", bus.wr_en, 0);
    chk("rst compare_only", bus.compare_only, 0);
    chk("rst done", done, 0);
    chk("rst converged", converged, 0);
    chk("rst iter_count", iter_count, 0);
    reset = 1'b1;

    run("zero_n", 0, 2, 1, -1, 0, 0, 0, 0, 0, 0);
    run("zero_k", 5, 0, 1, -1, 0, 0, 0, 0, 0, 0);
    run("basic", 4, 2, 1, -1, 0, 0, 1, 1, 4, 4);
    run("maxiter", 3, 3, 0, -1, 0, 0, 3, 0, 9, 3);
    run("tie", 1, 2, 3, -1, 0, 0, 3, 1, 3, 1);
    run("stall", 3, 1, 2, 1, 0, 1, 2, 1, 6, 3);
    run("labdly", 2, 4, 1, -1, 4, 0, 1, 1, 2, 2);

    // Asynchronous reset while waiting for the label of pixel 2.
    build(4, 2, 1, mi, mc, mrd);
    setup(1, -1, 6, 0);
    @(negedge clk);
    image_size = ADDR_W'(4); k_cores = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && wxf_cnt < 3; c++) @(negedge clk);
    chk("abort reached_pix2", wxf_cnt, 3);
    chk("abort writes_before", wr_cnt, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort mem_rd", bus.mem_rd, 0);
    chk("abort pix_valid", bus.pix_valid, 0);
    chk("abort compare_only", bus.compare_only, 0);
    chk("abort wr_en", bus.wr_en, 0);
    chk("abort update_mean", bus.update_mean, 0);
    chk("abort done", done, 0);
    chk("abort converged", converged, 0);
    chk("abort iter_count", iter_count, 0);
    repeat (3) @(negedge clk);
    chk("abort no_writeback", wr_cnt, 2);
    reset = 1'b1;
    run("restart", 4, 2, 1, -1, 0, 0, 1, 1, 4, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
